// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline types for the hazard unit
// Purpose: forwarding-select encodings, branch-stage identifiers and the
//          shadow-pipeline slot record shared by hazard_unit and hazard_slot.
// Ports:   none (package).
package cpu_pkg;

  // Slot specifiers are stored at this fixed width; narrower register files
  // are zero-extended on entry so one record type serves every REG_AW.
  localparam int SLOT_AW = 8;
  typedef logic [SLOT_AW-1:0] reg_id_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam int BR_EX  = 2;
  localparam int BR_MEM = 3;

  typedef struct packed {
    logic    valid;
    reg_id_t rs;
    reg_id_t rt;
    reg_id_t rd;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
  } slot_t;

  // True when slot s will write a non-zero register equal to r.
  function automatic logic writes_reg(input slot_t s, input reg_id_t r);
    return s.valid & s.reg_write & (s.rd != '0) & (s.rd == r);
  endfunction

endpackage

// File: rtl/hazard_slot.sv
// rtl/hazard_slot.sv - one shadow-pipeline slot register
// Purpose: holds one instruction record; loads d, holds, or loads a bubble.
// Ports:   clk, reset (sync, active low), hold, bubble, d (next record),
//          q (current record).
module hazard_slot
  import cpu_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  hold,
  input  logic  bubble,
  input  slot_t d,
  output slot_t q
);

  // Hold wins over bubble: a frozen stage must keep its instruction.
  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (hold) begin
      q <= q;
    end else if (bubble) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard detection, forwarding and counters
// Purpose: tracks EX/MEM/WB in a shadow pipeline, drives forwarding selects,
//          stall/flush/bubble controls and stall/flush performance counters.
// Ports:   clk, reset (sync, active low); ID-stage instruction fields
//          (id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
//          id_reg_write, id_mem_read, id_mem_write); br_taken; dmem_ready;
//          stall_if/id/ex/mem, flush_if_id, bubble_ex/mem/wb, fwd_a, fwd_b,
//          stall_cnt, flush_cnt.
module hazard_unit
  import cpu_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int BR_STAGE = 2,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              br_taken,
  input  logic              dmem_ready,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              stall_mem,
  output logic              flush_if_id,
  output logic              bubble_ex,
  output logic              bubble_mem,
  output logic              bubble_wb,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  if (BR_STAGE != BR_EX && BR_STAGE != BR_MEM) begin : g_bad_br_stage
    $error("hazard_unit: BR_STAGE must be 2 or 3");
  end
  if (REG_AW > SLOT_AW) begin : g_bad_reg_aw
    $error("hazard_unit: REG_AW exceeds slot specifier width");
  end

  slot_t id_slot, ex_q, mem_q, wb_q;
  logic  mem_stall, br_ok, load_use;

  assign id_slot = '{
    valid:     id_valid,
    rs:        reg_id_t'(id_rs),
    rt:        reg_id_t'(id_rt),
    rd:        reg_id_t'(id_rd),
    reg_write: id_reg_write,
    mem_read:  id_mem_read,
    mem_write: id_mem_write
  };

  always_comb begin
    mem_stall = mem_q.valid & (mem_q.mem_read | mem_q.mem_write) & ~dmem_ready;
    // The branch source keeps br_taken asserted through a memory stall.
    br_ok     = br_taken & ~mem_stall;
    // A flush discards the ID instruction, so its load-use hazard is moot.
    load_use  = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rd != '0)
              & ((id_uses_rs & (id_slot.rs == ex_q.rd))
               | (id_uses_rt & (id_slot.rt == ex_q.rd)))
              & ~mem_stall & ~br_ok;

    stall_if    = mem_stall | load_use;
    stall_id    = mem_stall | load_use;
    stall_ex    = mem_stall;
    stall_mem   = mem_stall;
    flush_if_id = br_ok;
    bubble_ex   = br_ok | load_use;
    bubble_mem  = br_ok & (BR_STAGE == BR_MEM);
    bubble_wb   = mem_stall;

    if (writes_reg(mem_q, ex_q.rs))     fwd_a = FWD_MEM;
    else if (writes_reg(wb_q, ex_q.rs)) fwd_a = FWD_WB;
    else                                fwd_a = FWD_RF;

    if (writes_reg(mem_q, ex_q.rt))     fwd_b = FWD_MEM;
    else if (writes_reg(wb_q, ex_q.rt)) fwd_b = FWD_WB;
    else                                fwd_b = FWD_RF;
  end

  // Shadow slots consume exactly the controls driven to the datapath.
  hazard_slot u_ex_slot (
    .clk(clk), .reset(reset), .hold(stall_ex), .bubble(bubble_ex),
    .d(id_slot), .q(ex_q)
  );
  hazard_slot u_mem_slot (
    .clk(clk), .reset(reset), .hold(stall_mem), .bubble(bubble_mem),
    .d(ex_q), .q(mem_q)
  );
  hazard_slot u_wb_slot (
    .clk(clk), .reset(reset), .hold(1'b0), .bubble(bubble_wb),
    .d(mem_q), .q(wb_q)
  );

  // WB only ever sources a forward; its operand and memory fields are dead.
  logic unused_wb_fields;
  assign unused_wb_fields = ^{wb_q.rs, wb_q.rt, wb_q.mem_read, wb_q.mem_write};

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_if && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br_ok && flush_cnt != '1)    flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - self-checking bench for hazard_unit
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_uses_rs, id_uses_rt;
  logic       id_reg_write, id_mem_read, id_mem_write;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       br_taken, dmem_ready;

  logic        s2_if, s2_id, s2_ex, s2_mem, f2, bx2, bm2, bw2;
  logic [1:0]  fa2, fb2;
  logic [3:0]  sc2, fc2;
  logic        s3_if, s3_id, s3_ex, s3_mem, f3, bx3, bm3, bw3;
  logic [1:0]  fa3, fb3;
  logic [15:0] sc3, fc3;

  always #5 clk = ~clk;

  hazard_unit #(.REG_AW(5), .BR_STAGE(2), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .br_taken(br_taken), .dmem_ready(dmem_ready),
    .stall_if(s2_if), .stall_id(s2_id), .stall_ex(s2_ex), .stall_mem(s2_mem),
    .flush_if_id(f2), .bubble_ex(bx2), .bubble_mem(bm2), .bubble_wb(bw2),
    .fwd_a(fa2), .fwd_b(fb2), .stall_cnt(sc2), .flush_cnt(fc2)
  );

  hazard_unit #(.REG_AW(5), .BR_STAGE(3), .CNT_W(16)) dut3 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .br_taken(br_taken), .dmem_ready(dmem_ready),
    .stall_if(s3_if), .stall_id(s3_id), .stall_ex(s3_ex), .stall_mem(s3_mem),
    .flush_if_id(f3), .bubble_ex(bx3), .bubble_mem(bm3), .bubble_wb(bw3),
    .fwd_a(fa3), .fwd_b(fb3), .stall_cnt(sc3), .flush_cnt(fc3)
  );

  // {stall_if, stall_id, stall_ex, stall_mem, flush_if_id, bubble_ex,
  //  bubble_mem, bubble_wb, fwd_a, fwd_b}
  logic [11:0] obs2, obs3;
  assign obs2 = {s2_if, s2_id, s2_ex, s2_mem, f2, bx2, bm2, bw2, fa2, fb2};
  assign obs3 = {s3_if, s3_id, s3_ex, s3_mem, f3, bx3, bm3, bw3, fa3, fb3};

  typedef struct {
    logic       rst, v;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] rd;
    logic       rw, mr, mw, br, rdy;
    logic [11:0] e2, e3;
  } step_t;

  typedef struct {
    logic [11:0] e2, e3;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Argument order: rst, v, rs, rt, urs, urt, rd, rw, mr, mw, br, rdy, e2, e3
  function automatic step_t mk(input int rst, v, rs, rt, urs, urt, rd,
                               input int rw, mr, mw, br, rdy, e2, e3);
    step_t s;
    s.rst = rst[0]; s.v = v[0]; s.rs = rs[4:0]; s.rt = rt[4:0];
    s.urs = urs[0]; s.urt = urt[0]; s.rd = rd[4:0];
    s.rw = rw[0]; s.mr = mr[0]; s.mw = mw[0]; s.br = br[0]; s.rdy = rdy[0];
    s.e2 = e2[11:0]; s.e3 = e3[11:0];
    return s;
  endfunction

  function automatic step_t idle(input int br, rdy, e2, e3);
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, br, rdy, e2, e3);
  endfunction

  task automatic apply(input step_t s);
    exp_t e;
    reset = s.rst; id_valid = s.v; id_rs = s.rs; id_rt = s.rt;
    id_uses_rs = s.urs; id_uses_rt = s.urt; id_rd = s.rd;
    id_reg_write = s.rw; id_mem_read = s.mr; id_mem_write = s.mw;
    br_taken = s.br; dmem_ready = s.rdy;
    e.e2 = s.e2; e.e3 = s.e3;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clk);
    apply(idle(0, 1, 0, 0));
    reset = 1'b0;
    void'(sb.pop_back());
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); #1;
    n_vec += 4;
    if (obs2 !== 12'h000) begin n_err++; $display("FAIL reset_outs2 got %h want 000", obs2); end
    if (obs3 !== 12'h000) begin n_err++; $display("FAIL reset_outs3 got %h want 000", obs3); end
    if ({sc2, fc2} !== 8'h00) begin n_err++; $display("FAIL reset_cnt2 got %h want 00", {sc2, fc2}); end
    if ({sc3, fc3} !== 32'h0) begin n_err++; $display("FAIL reset_cnt3 got %h want 0", {sc3, fc3}); end
  endtask

  task automatic test_back_to_back();
    step_t t[$];
    exp_t  e;
    do_reset();
    t.push_back(mk(1, 1, 1, 2, 1, 1, 3, 1, 0, 0, 0, 1, 'h000, 'h000)); // add r3,r1,r2
    t.push_back(mk(1, 1, 3, 5, 1, 1, 4, 1, 0, 0, 0, 1, 'h000, 'h000)); // sub r4,r3,r5
    t.push_back(mk(1, 1, 3, 4, 1, 1, 7, 1, 0, 0, 0, 1, 'h008, 'h008)); // and r7,r3,r4
    t.push_back(idle(0, 1, 'h006, 'h006));
    t.push_back(mk(1, 1, 1, 1, 1, 1, 3, 1, 0, 0, 0, 1, 'h000, 'h000)); // add r3,r1,r1
    t.push_back(mk(1, 1, 2, 2, 1, 1, 3, 1, 0, 0, 0, 1, 'h000, 'h000)); // add r3,r2,r2
    t.push_back(mk(1, 1, 3, 3, 1, 1, 9, 1, 0, 0, 0, 1, 'h000, 'h000)); // xor r9,r3,r3
    t.push_back(idle(0, 1, 'h00A, 'h00A));
    t.push_back(idle(0, 1, 'h000, 'h000));
    for (int i = 0; i < t.size(); i++) begin
      @(negedge clk); apply(t[i]); #1;
      e = sb.pop_front();
      n_vec += 2;
      if (obs2 !== e.e2) begin n_err++; $display("FAIL b2b[%0d] stage2 got %h want %h", i, obs2, e.e2); end
      if (obs3 !== e.e3) begin n_err++; $display("FAIL b2b[%0d] stage3 got %h want %h", i, obs3, e.e3); end
    end
    @(negedge clk); #1;
    n_vec += 1;
    if (sc2 !== 4'd0) begin n_err++; $display("FAIL b2b_nostall got %0d want 0", sc2); end
  endtask

  task automatic test_load_use();
    step_t t[$];
    exp_t  e;
    do_reset();
    t.push_back(mk(1, 1, 1, 2, 1, 0, 2, 1, 1, 0, 0, 1, 'h000, 'h000)); // lw r2,0(r1)
    t.push_back(mk(1, 1, 2, 2, 1, 1, 3, 1, 0, 0, 0, 1, 'hC40, 'hC40)); // add r3,r2,r2
    t.push_back(mk(1, 1, 2, 2, 1, 1, 3, 1, 0, 0, 0, 1, 'h000, 'h000)); // held add
    t.push_back(idle(0, 1, 'h005, 'h005));
    for (int i = 0; i < t.size(); i++) begin
      @(negedge clk); apply(t[i]); #1;
      e = sb.pop_front();
      n_vec += 2;
      if (obs2 !== e.e2) begin n_err++; $display("FAIL lduse[%0d] stage2 got %h want %h", i, obs2, e.e2); end
      if (obs3 !== e.e3) begin n_err++; $display("FAIL lduse[%0d] stage3 got %h want %h", i, obs3, e.e3); end
    end
    @(negedge clk); #1;
    n_vec += 2;
    if (sc2 !== 4'd1)  begin n_err++; $display("FAIL lduse_cnt2 got %0d want 1", sc2); end
    if (sc3 !== 16'd1) begin n_err++; $display("FAIL lduse_cnt3 got %0d want 1", sc3); end
  endtask

  task automatic test_reg_zero();
    step_t t[$];
    exp_t  e;
    do_reset();
    t.push_back(mk(1, 1, 1, 0, 1, 0, 0, 1, 1, 0, 0, 1, 'h000, 'h000)); // lw r0
    t.push_back(mk(1, 1, 0, 0, 1, 1, 0, 1, 0, 0, 0, 1, 'h000, 'h000)); // add r0,r0,r0
    t.push_back(mk(1, 1, 0, 0, 1, 1, 5, 1, 0, 0, 0, 1, 'h000, 'h000)); // add r5,r0,r0
    t.push_back(idle(0, 1, 'h000, 'h000));
    t.push_back(idle(0, 1, 'h000, 'h000));
    for (int i = 0; i < t.size(); i++) begin
      @(negedge clk); apply(t[i]); #1;
      e = sb.pop_front();
      n_vec += 2;
      if (obs2 !== e.e2) begin n_err++; $display("FAIL rzero[%0d] stage2 got %h want %h", i, obs2, e.e2); end
      if (obs3 !== e.e3) begin n_err++; $display("FAIL rzero[%0d] stage3 got %h want %h", i, obs3, e.e3); end
    end
    @(negedge clk); #1;
    n_vec += 1;
    if (sc3 !== 16'd0) begin n_err++; $display("FAIL rzero_cnt got %0d want 0", sc3); end
  endtask

  task automatic test_branch();
    step_t t[$];
    exp_t  e;
    do_reset();
    t.push_back(mk(1, 1, 1, 2, 1, 0, 2, 1, 1, 0, 0, 1, 'h000, 'h000)); // lw r2
    t.push_back(mk(1, 1, 2, 2, 1, 1, 3, 1, 0, 0, 1, 1, 'h0C0, 'h0E0)); // add r2 + branch
    t.push_back(idle(0, 1, 'h000, 'h000));
    t.push_back(idle(1, 1, 'h0C0, 'h0E0));
    t.push_back(idle(0, 1, 'h000, 'h000));
    for (int i = 0; i < t.size(); i++) begin
      @(negedge clk); apply(t[i]); #1;
      e = sb.pop_front();
      n_vec += 2;
      if (obs2 !== e.e2) begin n_err++; $display("FAIL branch[%0d] stage2 got %h want %h", i, obs2, e.e2); end
      if (obs3 !== e.e3) begin n_err++; $display("FAIL branch[%0d] stage3 got %h want %h", i, obs3, e.e3); end
    end
    @(negedge clk); #1;
    n_vec += 3;
    if (fc2 !== 4'd2)  begin n_err++; $display("FAIL branch_fcnt2 got %0d want 2", fc2); end
    if (fc3 !== 16'd2) begin n_err++; $display("FAIL branch_fcnt3 got %0d want 2", fc3); end
    if (sc2 !== 4'd0)  begin n_err++; $display("FAIL branch_scnt2 got %0d want 0", sc2); end
  endtask

  task automatic test_mem_stall();
    step_t t[$];
    exp_t  e;
    do_reset();
    t.push_back(mk(1, 1, 8, 8, 1, 1, 1, 1, 0, 0, 0, 1, 'h000, 'h000));  // add r1,r8,r8
    t.push_back(mk(1, 1, 9, 10, 1, 1, 0, 0, 0, 1, 0, 1, 'h000, 'h000)); // sw
    t.push_back(mk(1, 1, 1, 1, 1, 1, 6, 1, 0, 0, 0, 1, 'h000, 'h000));  // or r6,r1,r1
    t.push_back(idle(1, 0, 'hF15, 'hF15));
    t.push_back(idle(1, 0, 'hF10, 'hF10));
    t.push_back(idle(1, 0, 'hF10, 'hF10));
    t.push_back(idle(1, 1, 'h0C0, 'h0E0));
    t.push_back(idle(0, 1, 'h000, 'h000));
    for (int i = 0; i < t.size(); i++) begin
      @(negedge clk); apply(t[i]); #1;
      e = sb.pop_front();
      n_vec += 2;
      if (obs2 !== e.e2) begin n_err++; $display("FAIL mstall[%0d] stage2 got %h want %h", i, obs2, e.e2); end
      if (obs3 !== e.e3) begin n_err++; $display("FAIL mstall[%0d] stage3 got %h want %h", i, obs3, e.e3); end
    end
    @(negedge clk); #1;
    n_vec += 2;
    if ({sc2, fc2} !== {4'd3, 4'd1}) begin n_err++; $display("FAIL mstall_cnt2 got %h want 31", {sc2, fc2}); end
    if ({sc3, fc3} !== {16'd3, 16'd1}) begin n_err++; $display("FAIL mstall_cnt3 got %h want 00030001", {sc3, fc3}); end
  endtask

  task automatic test_reset_and_saturate();
    step_t t[$];
    exp_t  e;
    do_reset();
    t.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'h000, 'h000)); // sw
    t.push_back(idle(0, 1, 'h000, 'h000));
    t.push_back(idle(0, 0, 'hF10, 'hF10));
    t.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hF10, 'hF10)); // reset mid-stall
    t.push_back(idle(0, 0, 'h000, 'h000));
    // Second stall: 20 cycles, counter of dut2 must stop at 15.
    t.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 'h000, 'h000)); // sw
    t.push_back(idle(0, 0, 'h000, 'h000));
    for (int k = 0; k < 20; k++) t.push_back(idle(0, 0, 'hF10, 'hF10));
    t.push_back(idle(0, 1, 'h000, 'h000));
    for (int i = 0; i < t.size(); i++) begin
      @(negedge clk); apply(t[i]); #1;
      e = sb.pop_front();
      n_vec += 2;
      if (obs2 !== e.e2) begin n_err++; $display("FAIL rstsat[%0d] stage2 got %h want %h", i, obs2, e.e2); end
      if (obs3 !== e.e3) begin n_err++; $display("FAIL rstsat[%0d] stage3 got %h want %h", i, obs3, e.e3); end
      if (i == 4) begin
        n_vec += 1;
        if (sc3 !== 16'd0) begin n_err++; $display("FAIL rst_midstall_cnt got %0d want 0", sc3); end
      end
    end
    @(negedge clk); #1;
    n_vec += 2;
    if (sc2 !== 4'd15)  begin n_err++; $display("FAIL sat_cnt2 got %0d want 15", sc2); end
    if (sc3 !== 16'd20) begin n_err++; $display("FAIL sat_cnt3 got %0d want 20", sc3); end
  endtask

  initial begin
    apply(idle(0, 1, 0, 0));
    void'(sb.pop_back());
    reset = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_back_to_back();
    test_load_use();
    test_reg_zero();
    test_branch();
    test_mem_stall();
    test_reset_and_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
